mdu_writeback: RTL and testbench
================================

Name: mdu_writeback

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Drives a register-file write port (regwrite, wrreg, wrdata) for MFHI/MFLO results; sits directly upstream of the GPR file.
- Requests a pipeline stall while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- RADDR_W, 5, GPR address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request valid this cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO.
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- dst  in  RADDR_W  destination GPR for MFHI/MFLO.
- busy  out  1  mult/div in progress.
- stall_req  out  1  combinational; equals start && busy.
- regwrite  out  1  one-cycle GPR write strobe.
- wrreg  out  RADDR_W  GPR write address.
- wrdata  out  WIDTH  GPR write data.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_by_zero  out  1  one-cycle flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; hi, lo, busy, regwrite, wrreg, wrdata and div_by_zero all 0. Reset during an operation abandons it and leaves HI/LO at 0.
- States: IDLE, MUL, DIV, FIX.
- Request acceptance: only while start=1 and state=IDLE, at posedge. While busy, no request is consumed; stall_req=1 and upstream holds start/op/operands until busy falls.
- MULT/MULTU:
  - Accept: latch |a| and |b| (signed) or raw operands (unsigned) and sign flag; go to MUL; busy=1 from the next cycle.
  - MUL performs 32 radix-2 shift-add iterations, one per cycle, then FIX.
  - FIX negates the 64-bit product if the sign flag is set, writes {hi,lo}, returns to IDLE.
  - busy is high for exactly 33 cycles; new HI/LO are visible the cycle busy falls.
- DIV/DIVU:
  - Restoring division, 32 iterations in DIV, then FIX. Same 33-cycle busy.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (b==0 on DIV/DIVU): HI/LO unchanged; no busy; div_by_zero=1 for the one cycle after accept.
- MTHI/MTLO: hi or lo <= a at the accept edge; no busy, no regwrite.
- MFHI/MFLO:
  - At the accept edge: regwrite<=(dst!=0), wrreg<=dst, wrdata<=hi or lo (value before any same-edge update).
  - regwrite is high for exactly one cycle, then returns to 0.
  - wrreg/wrdata hold their last value.
- Outside MFHI/MFLO responses, regwrite=0.
- Simultaneous events:
  - start while busy is never accepted, whatever op is.
  - A request presented in the cycle busy falls is accepted, and MFHI/MFLO then return the new result.
- Width rule: all arithmetic is unsigned internally on 32-bit magnitudes with a 64-bit accumulator; signs are applied only in FIX.

Optional Feature:
- MDU_EARLY_OUT_EN defined: MUL leaves to FIX as soon as the remaining unshifted multiplier magnitude is zero.
  - busy length = max(1, index of MSB of multiplier magnitude + 1) + 1 cycles.
  - Multiplier 0 gives a 2-cycle busy.
  - Division timing is unchanged.
- Undefined: fixed 33-cycle multiply.
- Results are identical in both builds.

Test Plan:
- Reset: hold rst=0 mid-MULT -> hi=lo=0, busy=0, regwrite=0; after release, MFLO dst=3 -> regwrite pulse, wrreg=3, wrdata=0.
- MULT a=0xFFFFFFFD (-3), b=7 -> busy 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU same operands -> hi=0x6, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> div_by_zero pulse, HI/LO unchanged, busy never set.
- MFHI dst=5 issued while busy -> stall_req=1 each cycle, no regwrite; accepted in the cycle busy falls -> regwrite=1, wrreg=5, wrdata=new hi.
- MTLO a=0x12345678, then MFLO dst=0 -> lo=0x12345678, regwrite stays 0. MFLO dst=9 -> wrdata=0x12345678.
- With MDU_EARLY_OUT_EN: MULTU a=5, b=3 -> busy 3 cycles, lo=0xF, hi=0. Without the macro -> busy 33 cycles, same result.

Source files
------------

// File: rtl/mdu_writeback.sv
// Iterative multiply/divide unit with HI/LO registers and a GPR write port for MFHI/MFLO.
// Optional build macro MDU_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module mdu_writeback #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [RADDR_W-1:0] dst,
   output logic               busy,
   output logic               stall_req,
   output logic               regwrite,
   output logic [RADDR_W-1:0] wrreg,
   output logic [WIDTH-1:0]   wrdata,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic               div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned ACC_W = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MFHI  = 3'b110;
   localparam logic [2:0] OP_MFLO  = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic                 busy_q, busy_d;
   logic                 regwrite_q, regwrite_d;
   logic [RADDR_W-1:0]   wrreg_q, wrreg_d;
   logic [WIDTH-1:0]     wrdata_q, wrdata_d;
   logic                 dbz_q, dbz_d;
   logic [ACC_W-1:0]     acc_q, acc_d;   // product, or {remainder, quotient/dividend}
   logic [ACC_W-1:0]     sh_q, sh_d;     // left-shifting multiplicand
   logic [WIDTH-1:0]     opb_q, opb_d;   // right-shifting multiplier, or divisor
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic                 is_div_q, is_div_d;

   logic                 signed_op, a_neg, b_neg, mul_done;
   logic [WIDTH-1:0]     abs_a, abs_b, fix_q, fix_r;
   logic [WIDTH:0]       rem_ext, trial;
   logic [ACC_W-1:0]     prod;

   // Multiply termination: fixed count, or early once no multiplier bits remain
`ifdef MDU_EARLY_OUT_EN
   assign mul_done = (cnt_q == CNT_LAST) || (opb_q[WIDTH-1:1] == '0);
`else
   assign mul_done = (cnt_q == CNT_LAST);
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         regwrite_q <= 1'b0;
         wrreg_q    <= '0;
         wrdata_q   <= '0;
         dbz_q      <= 1'b0;
         acc_q      <= '0;
         sh_q       <= '0;
         opb_q      <= '0;
         cnt_q      <= '0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         is_div_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         regwrite_q <= regwrite_d;
         wrreg_q    <= wrreg_d;
         wrdata_q   <= wrdata_d;
         dbz_q      <= dbz_d;
         acc_q      <= acc_d;
         sh_q       <= sh_d;
         opb_q      <= opb_d;
         cnt_q      <= cnt_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         is_div_q   <= is_div_d;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      busy_d     = busy_q;
      regwrite_d = 1'b0;
      wrreg_d    = wrreg_q;
      wrdata_d   = wrdata_q;
      dbz_d      = 1'b0;
      acc_d      = acc_q;
      sh_d       = sh_q;
      opb_d      = opb_q;
      cnt_d      = cnt_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      is_div_d   = is_div_q;

      signed_op  = ~op[0];
      a_neg      = signed_op & a[WIDTH-1];
      b_neg      = signed_op & b[WIDTH-1];
      abs_a      = a_neg ? (~a + WIDTH'(1)) : a;
      abs_b      = b_neg ? (~b + WIDTH'(1)) : b;

      rem_ext    = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
      trial      = rem_ext - {1'b0, opb_q};
      fix_q      = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
      fix_r      = neg_hi_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];
      prod       = neg_lo_q ? (~acc_q + ACC_W'(1)) : acc_q;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     acc_d    = '0;
                     sh_d     = {{WIDTH{1'b0}}, abs_a};
                     opb_d    = abs_b;
                     cnt_d    = '0;
                     neg_lo_d = a_neg ^ b_neg;
                     neg_hi_d = a_neg ^ b_neg;
                     is_div_d = 1'b0;
                     busy_d   = 1'b1;
                     state_d  = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (b == '0) begin
                        dbz_d = 1'b1;
                     end else begin
                        acc_d    = {{WIDTH{1'b0}}, abs_a};
                        opb_d    = abs_b;
                        cnt_d    = '0;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        is_div_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = S_DIV;
                     end
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  OP_MFHI: begin
                     regwrite_d = (dst != '0);
                     wrreg_d    = dst;
                     wrdata_d   = hi_q;
                  end
                  OP_MFLO: begin
                     regwrite_d = (dst != '0);
                     wrreg_d    = dst;
                     wrdata_d   = lo_q;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (opb_q[0]) acc_d = acc_q + sh_q;
            sh_d  = sh_q << 1;
            opb_d = opb_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (mul_done) state_d = S_FIX;
         end
         S_DIV: begin
            // Restoring step: keep the subtraction only when it does not borrow
            if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else               acc_d = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               lo_d = fix_q;
               hi_d = fix_r;
            end else begin
               hi_d = prod[ACC_W-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = busy_q;
   assign stall_req   = start && busy_q;
   assign regwrite    = regwrite_q;
   assign wrreg       = wrreg_q;
   assign wrdata      = wrdata_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_writeback.sv
// Directed self-checking bench for mdu_writeback (build with or without MDU_EARLY_OUT_EN).
module tb_mdu_writeback;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [4:0]  dst;
   logic        busy, stall_req, regwrite, div_by_zero;
   logic [4:0]  wrreg;
   logic [31:0] wrdata, hi, lo;

   int checks = 0;
   int errors = 0;

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   mdu_writeback #(.WIDTH(32), .RADDR_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
      .busy(busy), .stall_req(stall_req), .regwrite(regwrite), .wrreg(wrreg),
      .wrdata(wrdata), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [4:0] d);
      start = 1'b1; op = o; a = ia; b = ib; dst = d;
      tick();
      start = 1'b0;
   endtask

   // Counts busy cycles after an accept, bounded so a stuck busy cannot hang the run
   task automatic wait_busy(input string tag, input int exp_cycles);
      int n = 0;
      while (busy && n < 200) begin
         n++;
         tick();
      end
      check(tag, 64'(n), 64'(exp_cycles));
   endtask

   initial begin
      int n;
      rst = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0; dst = '0;
      repeat (2) tick();
      check("rst_hi", 64'(hi), 64'h0);
      check("rst_lo", 64'(lo), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_regwrite", 64'(regwrite), 64'h0);
      check("rst_wrreg", 64'(wrreg), 64'h0);
      check("rst_wrdata", 64'(wrdata), 64'h0);
      check("rst_dbz", 64'(div_by_zero), 64'h0);
      rst = 1'b1;
      tick();

      // Reset in the middle of a multiply
      issue(3'b101, 32'hDEADBEEF, 32'h0, 5'd0);
      check("mtlo_pre_rst", 64'(lo), 64'hDEADBEEF);
      issue(3'b000, 32'h0000_0011, 32'h0000_0013, 5'd0);
      repeat (3) tick();
      check("mid_mult_busy", 64'(busy), 64'h1);
      rst = 1'b0;
      #1;
      check("async_rst_busy", 64'(busy), 64'h0);
      check("async_rst_lo", 64'(lo), 64'h0);
      check("async_rst_hi", 64'(hi), 64'h0);
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_busy", 64'(busy), 64'h0);
      issue(3'b111, 32'h0, 32'h0, 5'd3);
      check("mflo3_regwrite", 64'(regwrite), 64'h1);
      check("mflo3_wrreg", 64'(wrreg), 64'd3);
      check("mflo3_wrdata", 64'(wrdata), 64'h0);
      tick();
      check("mflo3_pulse_end", 64'(regwrite), 64'h0);

      // MULT -3 * 7 and MULTU of the same bit patterns
      issue(3'b000, 32'hFFFF_FFFD, 32'd7, 5'd0);
      wait_busy("mult_busy_len", EARLY ? 4 : 33);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
      issue(3'b001, 32'hFFFF_FFFD, 32'd7, 5'd0);
      wait_busy("multu_busy_len", EARLY ? 4 : 33);
      check("multu_hi", 64'(hi), 64'h6);
      check("multu_lo", 64'(lo), 64'hFFFF_FFEB);

      // Signed and unsigned divides
      issue(3'b010, 32'hFFFF_FFF9, 32'd2, 5'd0);
      wait_busy("div_busy_len", 33);
      check("div_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi), 64'hFFFF_FFFF);
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
      wait_busy("div_ovf_busy_len", 33);
      check("div_ovf_lo", 64'(lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(hi), 64'h0);
      issue(3'b011, 32'd100, 32'd7, 5'd0);
      wait_busy("divu_busy_len", 33);
      check("divu_lo", 64'(lo), 64'd14);
      check("divu_hi", 64'(hi), 64'd2);

      // Divide by zero leaves HI/LO untouched
      issue(3'b011, 32'd7, 32'd0, 5'd0);
      check("dbz_flag", 64'(div_by_zero), 64'h1);
      check("dbz_busy", 64'(busy), 64'h0);
      tick();
      check("dbz_flag_end", 64'(div_by_zero), 64'h0);
      check("dbz_busy_after", 64'(busy), 64'h0);
      check("dbz_lo", 64'(lo), 64'd14);
      check("dbz_hi", 64'(hi), 64'd2);

      // MFHI held while busy, accepted the cycle busy falls
      issue(3'b001, 32'h0001_0000, 32'h0001_0000, 5'd0);
      start = 1'b1; op = 3'b110; a = '0; b = '0; dst = 5'd5;
      n = 0;
      while (busy && n < 200) begin
         check("stall_req_held", 64'(stall_req), 64'h1);
         check("no_regwrite_busy", 64'(regwrite), 64'h0);
         n++;
         tick();
      end
      check("mfhi_wait_len", 64'(n), EARLY ? 64'd18 : 64'd33);
      check("stall_req_clear", 64'(stall_req), 64'h0);
      tick();
      start = 1'b0;
      check("mfhi5_regwrite", 64'(regwrite), 64'h1);
      check("mfhi5_wrreg", 64'(wrreg), 64'd5);
      check("mfhi5_wrdata", 64'(wrdata), 64'h1);
      tick();
      check("mfhi5_pulse_end", 64'(regwrite), 64'h0);
      check("mfhi5_wrdata_hold", 64'(wrdata), 64'h1);

      // MTHI/MTLO and MFLO to r0 versus r9
      issue(3'b100, 32'hCAFE_F00D, 32'h0, 5'd0);
      check("mthi_hi", 64'(hi), 64'hCAFE_F00D);
      issue(3'b101, 32'h1234_5678, 32'h0, 5'd0);
      check("mtlo_lo", 64'(lo), 64'h1234_5678);
      check("mtlo_no_regwrite", 64'(regwrite), 64'h0);
      check("mtlo_no_busy", 64'(busy), 64'h0);
      issue(3'b111, 32'h0, 32'h0, 5'd0);
      check("mflo0_regwrite", 64'(regwrite), 64'h0);
      check("mflo0_wrdata", 64'(wrdata), 64'h1234_5678);
      issue(3'b111, 32'h0, 32'h0, 5'd9);
      check("mflo9_regwrite", 64'(regwrite), 64'h1);
      check("mflo9_wrreg", 64'(wrreg), 64'd9);
      check("mflo9_wrdata", 64'(wrdata), 64'h1234_5678);
      tick();
      check("mflo9_pulse_end", 64'(regwrite), 64'h0);

      // Short multiplier and zero multiplier
      issue(3'b001, 32'd5, 32'd3, 5'd0);
      wait_busy("multu53_busy_len", EARLY ? 3 : 33);
      check("multu53_lo", 64'(lo), 64'hF);
      check("multu53_hi", 64'(hi), 64'h0);
      issue(3'b000, 32'h0000_1234, 32'd0, 5'd0);
      wait_busy("mult_zero_busy_len", EARLY ? 2 : 33);
      check("mult_zero_hi", 64'(hi), 64'h0);
      check("mult_zero_lo", 64'(lo), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
